ap_fifo_rd_bridge: RTL and testbench
====================================

AP_FIFO_RD_BRIDGE -- requirements
Module: ap_fifo_rd_bridge

Interface
REQ-001 Parameter: DATA_W, default 32, stream word width in bits.
REQ-002 Parameter: DEPTH, default 16, buffer depth in words; power of two, minimum 2.
REQ-003 Port: ap_clk  input  1  single clock for all logic.
REQ-004 Port: ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: out_V_V_din  input  DATA_W  HLS ap_fifo write data.
REQ-006 Port: out_V_V_write  input  1  HLS write strobe.
REQ-007 Port: out_V_V_full_n  output  1  not-full indication to HLS core.
REQ-008 Port: ap_done  input  1  one-cycle pulse from HLS core, meaning end of stream.
REQ-009 Port: user_r_rden  input  1  Xillybus-style read enable.
REQ-010 Port: user_r_empty  output  1  buffer-empty indication.
REQ-011 Port: user_r_data  output  DATA_W  read data, registered.
REQ-012 Port: user_r_eof  output  1  end-of-file indication.
REQ-013 Port: user_r_open  input  1  consumer device-file open.
REQ-014 Port: level  output  $clog2(DEPTH)+1  current word count.
REQ-015 Port: err_ovf  output  1  sticky flag, meaning a write was attempted while full.
REQ-016 Port: err_udf  output  1  sticky flag, meaning a read was attempted while empty.

Function
REQ-017 The block shall be a single-clock circular buffer with a write pointer, a read pointer and a count (0..DEPTH); pointers shall wrap modulo DEPTH.
REQ-018 The write side shall accept a word when out_V_V_write=1 and out_V_V_full_n=1.
REQ-019 out_V_V_full_n shall be combinational: (count != DEPTH) OR (user_r_open=0).
REQ-020 The read side shall accept a read when user_r_rden=1 and user_r_empty=0; user_r_data shall show the oldest word on the next edge, which is one-cycle latency.
REQ-021 user_r_data shall hold its last value when no read is accepted.
REQ-022 user_r_empty shall be combinational: count == 0.
REQ-023 A word written at edge N shall be readable at the earliest from edge N+1; there is no write-to-read bypass.
REQ-024 Accepted write and accepted read in the same cycle: count unchanged, both pointers advance.
REQ-025 Write when count==DEPTH with open=1: the write is dropped, count is unchanged, err_ovf is set to 1.
REQ-026 Read when empty: the read is ignored, user_r_data holds, err_udf is set to 1.
REQ-027 When full, a same-cycle read does not admit a write; full_n is evaluated from the pre-edge count.
REQ-028 While user_r_open=0:
  - pointers, count and the done latch shall be forced to 0;
  - writes are accepted and discarded, so the HLS core never stalls;
  - user_r_eof=0;
  - err flags are cleared.
REQ-029 ap_done=1 with user_r_open=1 shall set the done latch, which stays set until user_r_open=0 or reset.
REQ-030 user_r_eof shall be registered: it is 1 on the edge after (done latch=1 AND count==0 AND user_r_open=1) holds, and it stays 1 while that condition holds.
REQ-031 Writes arriving after ap_done shall still be buffered; eof shall not assert until they are drained.
REQ-032 level shall equal count, registered with count.

Reset
REQ-033 On ap_rst_n=0, asynchronously:
  - pointers, count, level, done latch, user_r_eof, err_ovf, err_udf and user_r_data shall be set to 0;
  - user_r_empty shall be 1;
  - out_V_V_full_n shall be 1.
REQ-034 Reset release shall take effect on the first ap_clk edge with ap_rst_n=1; no extra latency is inserted.

Structure
REQ-035 Storage shall be an inferred register array of DEPTH x DATA_W, with no vendor primitives.
REQ-036 The shared package shall hold the default DATA_W and DEPTH constants and the level-width function; no typedefs are needed.
REQ-037 One sub-module is natural: ap_fifo_rd_bridge_eof, containing the done latch and the eof register; the rest shall be flat.

Verification
REQ-038 open=1; write 0x11..0x14 on consecutive cycles; then rden for 4 cycles -> data 0x11,0x12,0x13,0x14 on the edges following each rden; empty=1 after the 4th read; level 4->0.
REQ-039 Write 16 words without reads -> full_n=0 after the 16th; a 17th write is dropped and err_ovf=1; a read then restores full_n=1 the next cycle.
REQ-040 Simultaneous write and read at level=5 for 10 cycles -> level stays 5, data order preserved.
REQ-041 Write 3 words, pulse ap_done, write 1 more, read 4 -> eof=0 until the 4th read completes; eof=1 on the following edge and it holds; eof=0 after open=0.
REQ-042 rden while empty -> err_udf=1 and user_r_data unchanged; with open=0, 20 writes -> full_n stays 1 and level stays 0.
REQ-043 Assert ap_rst_n=0 mid-stream at level=7, asynchronously between edges -> all outputs immediately take their REQ-033 values.

Source files
------------

// File: rtl/ap_fifo_rd_bridge_pkg.sv
// Shared constants for the HLS ap_fifo -> Xillybus read bridge.
//   DEFAULT_DATA_W : default stream word width
//   DEFAULT_DEPTH  : default buffer depth (power of two, >= 2)
//   level_w()      : width of a word counter that can hold 0..depth
package ap_fifo_rd_bridge_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ap_fifo_rd_bridge_if.sv
// Stream bundle between the HLS core (ap_fifo write side) and the
// Xillybus-style consumer (read side).
// Handshake: a word moves on the write side on a clock edge where
// out_V_V_write=1 and out_V_V_full_n=1; a read is taken on an edge where
// user_r_rden=1 and user_r_empty=0, and user_r_data carries that word
// after the edge.
//   master : environment side (HLS core + consumer), drives strobes/data
//   slave  : bridge side, drives flow control, read data and eof
interface ap_fifo_rd_bridge_if
  import ap_fifo_rd_bridge_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic [DATA_W-1:0] out_V_V_din;
  logic              out_V_V_write;
  logic              out_V_V_full_n;
  logic              ap_done;
  logic              user_r_rden;
  logic              user_r_empty;
  logic [DATA_W-1:0] user_r_data;
  logic              user_r_eof;
  logic              user_r_open;

  modport master (
    output out_V_V_din, out_V_V_write, ap_done, user_r_rden, user_r_open,
    input  out_V_V_full_n, user_r_empty, user_r_data, user_r_eof
  );

  modport slave (
    input  out_V_V_din, out_V_V_write, ap_done, user_r_rden, user_r_open,
    output out_V_V_full_n, user_r_empty, user_r_data, user_r_eof
  );

endinterface

// File: rtl/ap_fifo_rd_bridge_eof.sv
// End-of-file tracking: latches the HLS ap_done pulse and raises eof once
// the buffer has drained after it.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   open             : consumer has the device file open
//   ap_done          : one-cycle end-of-stream pulse
//   buf_empty        : buffer word count is zero
//   eof              : registered end-of-file flag
//   done_latched     : current done latch (observability)
module ap_fifo_rd_bridge_eof (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic open,
  input  logic ap_done,
  input  logic buf_empty,
  output logic eof,
  output logic done_latched
);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      done_latched <= 1'b0;
      eof          <= 1'b0;
    end else if (!open) begin
      done_latched <= 1'b0;
      eof          <= 1'b0;
    end else begin
      if (ap_done) done_latched <= 1'b1;
      // Uses the pre-edge latch, so words written after ap_done must drain
      // before eof can rise.
      eof <= done_latched && buf_empty;
    end
  end

endmodule

// File: rtl/ap_fifo_rd_bridge.sv
// Circular buffer bridging an HLS ap_fifo output to a Xillybus-style read
// FIFO port, with end-of-file signalling and sticky error flags.
//   ap_clk, ap_rst_n : single clock, async active-low reset
//   bus              : stream bundle (slave side)
//   level            : current word count
//   err_ovf          : sticky, write attempted while full
//   err_udf          : sticky, read attempted while empty
// While the consumer has the file closed, the buffer is held empty and
// writes are swallowed so the HLS core never stalls.
module ap_fifo_rd_bridge
  import ap_fifo_rd_bridge_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  ap_fifo_rd_bridge_if.slave          bus,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        err_ovf,
  output logic                        err_udf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);
  localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [DATA_W-1:0] rd_data;
  logic              is_full;
  logic              is_empty;
  logic              wr_acc;
  logic              wr_store;
  logic              rd_acc;
  logic              done_latched;

  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);

  assign bus.out_V_V_full_n = !is_full || !bus.user_r_open;
  assign bus.user_r_empty   = is_empty;
  assign bus.user_r_data    = rd_data;
  assign level              = count;

  // Accepted writes only land in storage while the file is open.
  assign wr_acc   = bus.out_V_V_write && bus.out_V_V_full_n;
  assign wr_store = wr_acc && bus.user_r_open;
  assign rd_acc   = bus.user_r_rden && !is_empty && bus.user_r_open;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (!bus.user_r_open) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      // Pointer width is exactly log2(DEPTH), so wrap is free.
      if (wr_store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_store, rd_acc})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      if (bus.out_V_V_write && !bus.out_V_V_full_n) err_ovf <= 1'b1;
      if (bus.user_r_rden && is_empty)              err_udf <= 1'b1;
    end
  end

  // Storage has no reset; only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge ap_clk) begin
    if (wr_store) mem[wr_ptr] <= bus.out_V_V_din;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   rd_data <= '0;
    else if (rd_acc) rd_data <= mem[rd_ptr];
  end

  ap_fifo_rd_bridge_eof u_eof (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .open         (bus.user_r_open),
    .ap_done      (bus.ap_done),
    .buf_empty    (is_empty),
    .eof          (bus.user_r_eof),
    .done_latched (done_latched)
  );

endmodule

// File: tb/tb_ap_fifo_rd_bridge.sv
// Directed bench for ap_fifo_rd_bridge with a reference model and an
// expected-data queue.
module tb_ap_fifo_rd_bridge;
  import ap_fifo_rd_bridge_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = level_w(DEPTH);

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  ap_fifo_rd_bridge_if #(.DATA_W(DATA_W)) bus ();
  logic [LVL_W-1:0] level;
  logic             err_ovf;
  logic             err_udf;

  ap_fifo_rd_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .level    (level),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
  );

  // ---------------- scoreboard / model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_data;
  logic              m_done, m_eof, m_ovf, m_udf;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_data = '0;
    m_done = 1'b0;
    m_eof  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".level"}, 64'(level), 64'(sz));
    check({tag, ".full_n"}, 64'(bus.out_V_V_full_n), 64'((sz != DEPTH) || !bus.user_r_open));
    check({tag, ".empty"}, 64'(bus.user_r_empty), 64'(sz == 0));
    check({tag, ".data"}, 64'(bus.user_r_data), 64'(m_data));
    check({tag, ".eof"}, 64'(bus.user_r_eof), 64'(m_eof));
    check({tag, ".ovf"}, 64'(err_ovf), 64'(m_ovf));
    check({tag, ".udf"}, 64'(err_udf), 64'(m_udf));
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // One clock cycle with the given strobes; model computes next state from
  // pre-edge values, then everything is compared after the edge.
  task automatic cycle(input string tag, input bit wr, input logic [DATA_W-1:0] d,
                       input bit rd, input bit done);
    int   sz;
    bit   op, fn, wacc, racc;
    logic n_eof, n_done, n_ovf, n_udf;
    bus.out_V_V_write = wr;
    bus.out_V_V_din   = d;
    bus.user_r_rden   = rd;
    bus.ap_done       = done;
    op   = bus.user_r_open;
    sz   = exp_q.size();
    fn   = (sz != DEPTH) || !op;
    wacc = wr && fn && op;
    racc = rd && (sz != 0) && op;
    n_eof  = op && m_done && (sz == 0);
    n_done = op && (m_done || done);
    n_ovf  = op && (m_ovf || (wr && !fn));
    n_udf  = op && (m_udf || (rd && sz == 0));
    tick();
    if (!op) exp_q.delete();
    else begin
      if (racc) m_data = exp_q.pop_front();
      if (wacc) exp_q.push_back(d);
    end
    m_eof = n_eof; m_done = n_done; m_ovf = n_ovf; m_udf = n_udf;
    check_all(tag);
    bus.out_V_V_write = 1'b0;
    bus.user_r_rden   = 1'b0;
    bus.ap_done       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ap_rst_n          = 1'b0;
    bus.user_r_open   = 1'b0;
    bus.out_V_V_write = 1'b0;
    bus.out_V_V_din   = '0;
    bus.user_r_rden   = 1'b0;
    bus.ap_done       = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #10;
    ap_rst_n        = 1'b1;
    bus.user_r_open = 1'b1;

    // Basic ordered write then read
    for (int i = 0; i < 4; i++) cycle("wr4", 1'b1, DATA_W'(32'h11 + i), 1'b0, 1'b0);
    check("wr4.level4", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      cycle("rd4", 1'b0, '0, 1'b1, 1'b0);
      check("rd4.value", 64'(bus.user_r_data), 64'(32'h11 + i));
    end
    check("rd4.empty", 64'(bus.user_r_empty), 64'd1);

    // Fill, overflow, recover
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    check("fill.full_n0", 64'(bus.out_V_V_full_n), 64'd0);
    cycle("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("ovf.flag", 64'(err_ovf), 64'd1);
    check("ovf.level", 64'(level), 64'(DEPTH));
    cycle("ovf.rd", 1'b0, '0, 1'b1, 1'b0);
    check("ovf.full_n1", 64'(bus.out_V_V_full_n), 64'd1);
    // full + same-cycle read: write still refused on pre-edge count
    cycle("ovf.refill", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    cycle("full.wr_rd", 1'b1, 32'hA5A5_0002, 1'b1, 1'b0);
    check("full.wr_rd.level", 64'(level), 64'(DEPTH - 1));
    while (exp_q.size() != 0) cycle("drain1", 1'b0, '0, 1'b1, 1'b0);
    bus.user_r_open = 1'b0;
    cycle("close1", 1'b0, '0, 1'b0, 1'b0);
    check("close1.ovf_clr", 64'(err_ovf), 64'd0);
    bus.user_r_open = 1'b1;

    // Simultaneous write and read at level 5
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("wr_rd", 1'b1, DATA_W'($urandom_range(0, 32'hFFFF)), 1'b1, 1'b0);
      check("wr_rd.level5", 64'(level), 64'd5);
    end
    while (exp_q.size() != 0) cycle("drain2", 1'b0, '0, 1'b1, 1'b0);

    // End of file after post-done writes drain
    for (int i = 0; i < 3; i++) cycle("eof.wr", 1'b1, DATA_W'(32'h100 + i), 1'b0, 1'b0);
    cycle("eof.done", 1'b0, '0, 1'b0, 1'b1);
    cycle("eof.late", 1'b1, 32'h0000_0103, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle("eof.rd", 1'b0, '0, 1'b1, 1'b0);
      check("eof.low", 64'(bus.user_r_eof), 64'd0);
    end
    check("eof.lastdata", 64'(bus.user_r_data), 64'h103);
    cycle("eof.rise", 1'b0, '0, 1'b0, 1'b0);
    check("eof.high", 64'(bus.user_r_eof), 64'd1);
    cycle("eof.hold", 1'b0, '0, 1'b0, 1'b0);
    check("eof.hold1", 64'(bus.user_r_eof), 64'd1);
    bus.user_r_open = 1'b0;
    cycle("eof.close", 1'b0, '0, 1'b0, 1'b0);
    check("eof.cleared", 64'(bus.user_r_eof), 64'd0);
    bus.user_r_open = 1'b1;

    // Underflow, then closed-file writes
    cycle("udf.wr", 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    cycle("udf.rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("udf", 1'b0, '0, 1'b1, 1'b0);
    check("udf.flag", 64'(err_udf), 64'd1);
    check("udf.hold", 64'(bus.user_r_data), 64'h0BAD_F00D);
    bus.user_r_open = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle("closed.wr", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
      check("closed.full_n", 64'(bus.out_V_V_full_n), 64'd1);
      check("closed.level", 64'(level), 64'd0);
    end
    bus.user_r_open = 1'b1;

    // Async reset mid-stream at level 7
    for (int i = 0; i < 7; i++) cycle("pre7", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    cycle("pre7.rd", 1'b0, '0, 1'b1, 1'b0);
    cycle("pre7.wr", 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    check("pre7.level", 64'(level), 64'd7);
    #2;
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    #3;
    ap_rst_n = 1'b1;
    cycle("post_rst", 1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    cycle("post_rst.rd", 1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
